// File: rtl/rdmx_pkg.sv
// Shared RDMX definitions: AXI constants and packet-length to burst-shape helpers.
// Used by both the transmit and receive sides.
package rdmx_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Widest supported beat in bytes (DW = 1024).
  localparam int unsigned MAX_BPB = 128;

  typedef enum logic [1:0] {
    StIdle,
    StAw,
    StW
  } rx_state_e;

  function automatic logic [16:0] plen_to_beats(input logic [15:0] plen, input int unsigned bpb);
    logic [16:0] beats;
    if (plen == '0) begin
      beats = 17'd1;
    end else if ({1'b0, plen} > 17'(256 * bpb)) begin
      beats = 17'd256;
    end else begin
      beats = ({1'b0, plen} + 17'(bpb - 1)) / 17'(bpb);
    end
    return beats;
  endfunction

  // LSB-first strobe for the final beat; zero-length packets carry no valid bytes.
  function automatic logic [MAX_BPB-1:0] last_strobe(input logic [15:0] plen,
                                                     input int unsigned bpb);
    logic [MAX_BPB-1:0] ones;
    logic [MAX_BPB-1:0] strb;
    logic [16:0]        rem;
    ones = '0;
    for (int i = 0; i < MAX_BPB; i++) begin
      if (i < bpb) ones[i] = 1'b1;
    end
    rem = {1'b0, plen} % 17'(bpb);
    if (plen == '0) begin
      strb = '0;
    end else if ({1'b0, plen} > 17'(256 * bpb)) begin
      strb = ones;
    end else if (rem == '0) begin
      strb = ones;
    end else begin
      strb = (MAX_BPB'(1) << rem) - MAX_BPB'(1);
    end
    return strb;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/rdmx_recv_be_if.sv
// Link-decoder streams plus the AXI4 write port of the RDMX receive back end.
// master: the back end itself; slave: the link decoder and memory side.
interface rdmx_recv_be_if #(
  parameter int unsigned DW = 512,
  parameter int unsigned AW = 64,
  parameter int unsigned UW = 40
);
  logic [15:0]     axis_plen_tdata;
  logic            axis_plen_tvalid;
  logic            axis_plen_tready;

  logic [AW-1:0]   axis_addr_tdata;
  logic [UW-1:0]   axis_addr_tuser;
  logic            axis_addr_tvalid;
  logic            axis_addr_tready;

  logic [DW-1:0]   axis_data_tdata;
  logic            axis_data_tlast;
  logic            axis_data_tvalid;
  logic            axis_data_tready;

  logic [AW-1:0]   m_axi_awaddr;
  logic [UW-1:0]   m_axi_awuser;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid;
  logic            m_axi_awready;

  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready;

  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;

  modport master (
    input  axis_plen_tdata, axis_plen_tvalid,
    output axis_plen_tready,
    input  axis_addr_tdata, axis_addr_tuser, axis_addr_tvalid,
    output axis_addr_tready,
    input  axis_data_tdata, axis_data_tlast, axis_data_tvalid,
    output axis_data_tready,
    output m_axi_awaddr, m_axi_awuser, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output axis_plen_tdata, axis_plen_tvalid,
    input  axis_plen_tready,
    output axis_addr_tdata, axis_addr_tuser, axis_addr_tvalid,
    input  axis_addr_tready,
    output axis_data_tdata, axis_data_tlast, axis_data_tvalid,
    input  axis_data_tready,
    input  m_axi_awaddr, m_axi_awuser, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/rdmx_strb_gen.sv
// Combinational packet length to burst shape: beat count, final-beat strobe, oversize flag.
module rdmx_strb_gen
  import rdmx_pkg::*;
#(
  parameter int unsigned DW = 512
) (
  input  logic [15:0]     plen,
  output logic [16:0]     beats,
  output logic [DW/8-1:0] last_strb,
  output logic            oversize
);

  localparam int unsigned BPB = DW / 8;

  always_comb begin
    beats     = plen_to_beats(plen, BPB);
    last_strb = BPB'(last_strobe(plen, BPB));
    oversize  = {1'b0, plen} > 17'(256 * BPB);
  end

endmodule

// File: rtl/rdmx_recv_be.sv
// RDMX receive back end: one AXI4 INCR write burst per packet, W passed straight through
// from the data stream, with outstanding-response tracking and saturating error counters.
module rdmx_recv_be
  import rdmx_pkg::*;
#(
  parameter int unsigned DW      = 512,
  parameter int unsigned AW      = 64,
  parameter int unsigned UW      = 40,
  parameter int unsigned MAX_OUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  rdmx_recv_be_if.master             bus,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic [31:0]                tlast_err_cnt,
  output logic [31:0]                bresp_err_cnt,
  output logic [31:0]                oversize_cnt
);

  localparam int unsigned BPB      = DW / 8;
  localparam int unsigned OW       = $clog2(MAX_OUT) + 1;
  localparam logic [2:0]  AXI_SIZE = 3'($clog2(BPB));

  rx_state_e      state_q, state_d;
  logic [7:0]     beat_q, beat_d;
  logic [AW-1:0]  awaddr_q;
  logic [UW-1:0]  awuser_q;
  logic [7:0]     awlen_q;
  logic [2:0]     awsize_q;
  logic [1:0]     awburst_q;
  logic [BPB-1:0] last_strb_q;
  logic           bready_q;
  logic [OW-1:0]  out_q;
  logic [31:0]    tlast_err_q, bresp_err_q, oversize_q;

  logic [16:0]    beats;
  logic [BPB-1:0] last_strb;
  logic           oversize;
  logic           pop, aw_hs, w_hs, b_hs, last_beat;

  rdmx_strb_gen #(
    .DW(DW)
  ) u_strb_gen (
    .plen      (bus.axis_plen_tdata),
    .beats     (beats),
    .last_strb (last_strb),
    .oversize  (oversize)
  );

  assign last_beat = (beat_q == awlen_q);
  assign aw_hs     = (state_q == StAw) && bus.m_axi_awready;
  assign w_hs      = (state_q == StW) && bus.axis_data_tvalid && bus.m_axi_wready;
  assign b_hs      = bus.m_axi_bvalid && bready_q;

  always_comb begin
    state_d              = state_q;
    beat_d               = beat_q;
    pop                  = 1'b0;
    bus.axis_plen_tready = 1'b0;
    bus.axis_addr_tready = 1'b0;
    bus.axis_data_tready = 1'b0;
    bus.m_axi_awvalid    = 1'b0;
    bus.m_axi_wvalid     = 1'b0;
    unique case (state_q)
      StIdle: begin
        pop = bus.axis_plen_tvalid && bus.axis_addr_tvalid && (out_q < OW'(MAX_OUT));
        bus.axis_plen_tready = pop;
        bus.axis_addr_tready = pop;
        if (pop) begin
          state_d = StAw;
          beat_d  = '0;
        end
      end
      StAw: begin
        bus.m_axi_awvalid = 1'b1;
        if (bus.m_axi_awready) state_d = StW;
      end
      StW: begin
        // Zero-latency pass-through: stalls on either side propagate directly.
        bus.m_axi_wvalid     = bus.axis_data_tvalid;
        bus.axis_data_tready = bus.m_axi_wready;
        if (w_hs) begin
          if (last_beat) state_d = StIdle;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      awaddr_q    <= '0;
      awuser_q    <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      last_strb_q <= '0;
      bready_q    <= 1'b0;
      out_q       <= '0;
      tlast_err_q <= '0;
      bresp_err_q <= '0;
      oversize_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      bready_q <= 1'b1;
      if (pop) begin
        awaddr_q    <= bus.axis_addr_tdata;
        awuser_q    <= bus.axis_addr_tuser;
        awlen_q     <= 8'(beats - 17'd1);
        awsize_q    <= AXI_SIZE;
        awburst_q   <= AXI_BURST_INCR;
        last_strb_q <= last_strb;
      end
      if (aw_hs && !b_hs) begin
        out_q <= out_q + OW'(1);
      end else if (!aw_hs && b_hs) begin
        out_q <= out_q - OW'(1);
      end
      oversize_q  <= sat_inc(oversize_q, pop && oversize);
      // TLAST is only audited; framing always follows AWLEN.
      tlast_err_q <= sat_inc(tlast_err_q, w_hs && (bus.axis_data_tlast != last_beat));
      bresp_err_q <= sat_inc(bresp_err_q, b_hs && (bus.m_axi_bresp != AXI_RESP_OKAY));
    end
  end

  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awuser  = awuser_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = awsize_q;
  assign bus.m_axi_awburst = awburst_q;
  assign bus.m_axi_wdata   = bus.axis_data_tdata;
  assign bus.m_axi_wstrb   = last_beat ? last_strb_q : '1;
  assign bus.m_axi_wlast   = (state_q == StW) && last_beat;
  assign bus.m_axi_bready  = bready_q;

  assign outstanding   = out_q;
  assign tlast_err_cnt = tlast_err_q;
  assign bresp_err_cnt = bresp_err_q;
  assign oversize_cnt  = oversize_q;

endmodule

// File: tb/tb_rdmx_recv_be.sv
// Bench for rdmx_recv_be: vector table, outstanding-limit and mid-burst reset sequences,
// and a randomly back-pressured packet run, all checked through AW/W scoreboards.
module tb_rdmx_recv_be;
  import rdmx_pkg::*;

  localparam int unsigned DW      = 512;
  localparam int unsigned AW      = 64;
  localparam int unsigned UW      = 40;
  localparam int unsigned MAX_OUT = 16;
  localparam int unsigned BPB     = DW / 8;
  localparam int unsigned OW      = $clog2(MAX_OUT) + 1;
  localparam logic [BPB-1:0] ONES = '1;

  typedef struct {
    logic [15:0]   plen;
    logic [AW-1:0] addr;
    logic [UW-1:0] user;
  } pa_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [UW-1:0] user;
    logic [7:0]    len;
  } awexp_t;
  typedef struct {
    logic [DW-1:0]  data;
    logic [BPB-1:0] strb;
    logic           last;
  } wexp_t;
  typedef struct {
    logic [15:0]    plen;
    logic [AW-1:0]  addr;
    logic [UW-1:0]  user;
    int             tl;    // beat carrying TLAST, -1 for the proper last beat
    logic [7:0]     len;
    logic [BPB-1:0] strb;
    int             ovs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rdmx_recv_be_if #(.DW(DW), .AW(AW), .UW(UW)) bif ();

  logic [OW-1:0] outstanding;
  logic [31:0]   tlast_err_cnt, bresp_err_cnt, oversize_cnt;

  rdmx_recv_be #(
    .DW(DW), .AW(AW), .UW(UW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bif),
    .outstanding   (outstanding),
    .tlast_err_cnt (tlast_err_cnt),
    .bresp_err_cnt (bresp_err_cnt),
    .oversize_cnt  (oversize_cnt)
  );

  int checks = 0, errors = 0;
  int aw_cnt = 0, w_cnt = 0, bpend = 0, b_budget = 0;
  int exp_terr = 0, exp_ovs = 0, exp_berr = 0;
  int pv_pct = 100, dv_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100, b_err_pct = 0;
  bit b_force_err = 1'b0;
  bit pa_fire = 1'b0, d_fire = 1'b0, b_fire = 1'b0;
  pa_t    pa_q[$];
  beat_t  d_q[$];
  awexp_t aw_q[$];
  wexp_t  w_q[$];
  vec_t   vecs[11];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[UW-1:0];
  endfunction

  function automatic int m_beats(input int plen);
    if (plen == 0) return 1;
    if (plen > 256 * BPB) return 256;
    return (plen + BPB - 1) / BPB;
  endfunction

  function automatic logic [BPB-1:0] m_strb(input int plen);
    logic [BPB-1:0] s;
    int r;
    if (plen == 0) return '0;
    if (plen > 256 * BPB) return ONES;
    r = plen % BPB;
    if (r == 0) return ONES;
    s = '0;
    for (int i = 0; i < r; i++) s[i] = 1'b1;
    return s;
  endfunction

  task automatic send_pkt(input logic [15:0] plen, input logic [AW-1:0] addr,
                          input logic [UW-1:0] user, input logic [7:0] len,
                          input logic [BPB-1:0] lstrb, input int tl, input int ovs);
    pa_t p; awexp_t a; beat_t d; wexp_t w;
    p.plen = plen; p.addr = addr; p.user = user;
    a.addr = addr; a.user = user; a.len = len;
    pa_q.push_back(p);
    aw_q.push_back(a);
    for (int b = 0; b <= int'(len); b++) begin
      d.data = rand_data();
      d.last = (b == tl);
      d_q.push_back(d);
      w.data = d.data;
      w.last = (b == int'(len));
      w.strb = w.last ? lstrb : ONES;
      w_q.push_back(w);
      if (d.last != w.last) exp_terr++;
    end
    exp_ovs += ovs;
  endtask

  task automatic drain(input string nm, input int max_cyc);
    int n = 0;
    while ((pa_q.size() != 0 || d_q.size() != 0 || aw_q.size() != 0 || w_q.size() != 0 ||
            bpend != 0 || outstanding != '0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL drain_%s got=timeout exp=idle aw_left=%0d w_left=%0d", nm,
               aw_q.size(), w_q.size());
    end
  endtask

  // Monitor: handshakes are sampled on the falling edge and retire at the next rising edge.
  initial begin : monitor
    awexp_t a;
    wexp_t  w;
    forever begin
      @(negedge clk);
      if (reset) begin
        pa_fire = 1'b0; d_fire = 1'b0; b_fire = 1'b0;
      end else begin
        pa_fire = bif.axis_plen_tvalid && bif.axis_plen_tready;
        d_fire  = bif.axis_data_tvalid && bif.axis_data_tready;
        b_fire  = bif.m_axi_bvalid && bif.m_axi_bready;
        if (bif.axis_plen_tready || bif.axis_addr_tready)
          chk("tready_pair", DW'(bif.axis_plen_tready), DW'(bif.axis_addr_tready));
        if (bif.m_axi_awvalid && bif.m_axi_awready) begin
          aw_cnt++;
          bpend++;
          if (aw_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected got=handshake exp=none");
          end else begin
            a = aw_q.pop_front();
            chk("awaddr", DW'(bif.m_axi_awaddr), DW'(a.addr));
            chk("awuser", DW'(bif.m_axi_awuser), DW'(a.user));
            chk("awlen", DW'(bif.m_axi_awlen), DW'(a.len));
            chk("awsize", DW'(bif.m_axi_awsize), DW'(3'd6));
            chk("awburst", DW'(bif.m_axi_awburst), DW'(2'b01));
          end
        end
        if (bif.m_axi_wvalid && bif.m_axi_wready) begin
          w_cnt++;
          if (w_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected got=handshake exp=none");
          end else begin
            w = w_q.pop_front();
            chk("wdata", bif.m_axi_wdata, w.data);
            chk("wstrb", DW'(bif.m_axi_wstrb), DW'(w.strb));
            chk("wlast", DW'(bif.m_axi_wlast), DW'(w.last));
          end
        end
      end
    end
  end

  initial begin : pa_drv
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bif.axis_plen_tvalid = 1'b0; bif.axis_addr_tvalid = 1'b0;
      end else begin
        if (pa_fire) begin
          bif.axis_plen_tvalid = 1'b0; bif.axis_addr_tvalid = 1'b0;
          if (pa_q.size() != 0) pa_q.delete(0);
        end
        if (!bif.axis_plen_tvalid && pa_q.size() != 0 && $urandom_range(0, 99) < pv_pct) begin
          bif.axis_plen_tdata  = pa_q[0].plen;
          bif.axis_addr_tdata  = pa_q[0].addr;
          bif.axis_addr_tuser  = pa_q[0].user;
          bif.axis_plen_tvalid = 1'b1;
          bif.axis_addr_tvalid = 1'b1;
        end
      end
    end
  end

  initial begin : d_drv
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bif.axis_data_tvalid = 1'b0;
      end else begin
        if (d_fire) begin
          bif.axis_data_tvalid = 1'b0;
          if (d_q.size() != 0) d_q.delete(0);
        end
        if (!bif.axis_data_tvalid && d_q.size() != 0 && $urandom_range(0, 99) < dv_pct) begin
          bif.axis_data_tdata  = d_q[0].data;
          bif.axis_data_tlast  = d_q[0].last;
          bif.axis_data_tvalid = 1'b1;
        end
      end
    end
  end

  initial begin : rdy_drv
    forever begin
      @(posedge clk); #1;
      bif.m_axi_awready = !reset && ($urandom_range(0, 99) < aw_pct);
      bif.m_axi_wready  = !reset && ($urandom_range(0, 99) < w_pct);
    end
  end

  initial begin : b_drv
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bif.m_axi_bvalid = 1'b0;
      end else begin
        if (b_fire) begin
          bif.m_axi_bvalid = 1'b0;
          bpend--;
        end
        if (!bif.m_axi_bvalid && bpend > 0 && b_budget > 0 && $urandom_range(0, 99) < b_pct) begin
          if (b_force_err) bif.m_axi_bresp = 2'b10;
          else if ($urandom_range(0, 99) < b_err_pct) bif.m_axi_bresp = 2'($urandom_range(1, 3));
          else bif.m_axi_bresp = 2'b00;
          if (bif.m_axi_bresp != 2'b00) exp_berr++;
          bif.m_axi_bvalid = 1'b1;
          b_budget--;
        end
      end
    end
  end

  initial begin : main
    int base, n, plen;
    bif.axis_plen_tvalid = 1'b0; bif.axis_addr_tvalid = 1'b0; bif.axis_data_tvalid = 1'b0;
    bif.axis_plen_tdata = '0; bif.axis_addr_tdata = '0; bif.axis_addr_tuser = '0;
    bif.axis_data_tdata = '0; bif.axis_data_tlast = 1'b0;
    bif.m_axi_awready = 1'b0; bif.m_axi_wready = 1'b0;
    bif.m_axi_bvalid = 1'b0; bif.m_axi_bresp = 2'b00;

    vecs[0]  = '{16'd64,    64'h1000, 40'hAB, -1, 8'd0,   ONES,                    0};
    vecs[1]  = '{16'd200,   64'h2000, 40'h01, -1, 8'd3,   64'h0000_0000_0000_00FF, 0};
    vecs[2]  = '{16'd0,     64'h3000, 40'h02, -1, 8'd0,   64'h0,                   0};
    vecs[3]  = '{16'd20000, 64'h4000, 40'h03, -1, 8'd255, ONES,                    1};
    vecs[4]  = '{16'd256,   64'h5000, 40'h04,  1, 8'd3,   ONES,                    0};
    vecs[5]  = '{16'd1,     64'h6000, 40'h05, -1, 8'd0,   64'h1,                   0};
    vecs[6]  = '{16'd63,    64'h7000, 40'h06, -1, 8'd0,   64'h7FFF_FFFF_FFFF_FFFF, 0};
    vecs[7]  = '{16'd16384, 64'h8000, 40'h07, -1, 8'd255, ONES,                    0};
    vecs[8]  = '{16'd16385, 64'h9000, 40'h08, -1, 8'd255, ONES,                    1};
    vecs[9]  = '{16'd65,    64'hA000, 40'h09, -1, 8'd1,   64'h1,                   0};
    vecs[10] = '{16'd16383, 64'hB000, 40'h0A, -1, 8'd255, 64'h7FFF_FFFF_FFFF_FFFF, 0};

    repeat (3) @(negedge clk);
    chk("rst_awvalid", DW'(bif.m_axi_awvalid), '0);
    chk("rst_wvalid", DW'(bif.m_axi_wvalid), '0);
    chk("rst_bready", DW'(bif.m_axi_bready), '0);
    chk("rst_plen_tready", DW'(bif.axis_plen_tready), '0);
    chk("rst_data_tready", DW'(bif.axis_data_tready), '0);
    chk("rst_awlen", DW'(bif.m_axi_awlen), '0);
    chk("rst_awsize", DW'(bif.m_axi_awsize), '0);
    chk("rst_awburst", DW'(bif.m_axi_awburst), '0);
    chk("rst_awaddr", DW'(bif.m_axi_awaddr), '0);
    chk("rst_awuser", DW'(bif.m_axi_awuser), '0);
    chk("rst_outstanding", DW'(outstanding), '0);
    chk("rst_counters", DW'({tlast_err_cnt, bresp_err_cnt, oversize_cnt}), '0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("bready_after_reset", DW'(bif.m_axi_bready), DW'(1'b1));

    b_budget = 1000000;
    foreach (vecs[i]) begin
      send_pkt(vecs[i].plen, vecs[i].addr, vecs[i].user, vecs[i].len, vecs[i].strb,
               (vecs[i].tl < 0) ? int'(vecs[i].len) : vecs[i].tl, vecs[i].ovs);
      drain($sformatf("vec%0d", i), 2000);
      chk($sformatf("vec%0d_tlast_err", i), DW'(tlast_err_cnt), DW'(exp_terr));
      chk($sformatf("vec%0d_oversize", i), DW'(oversize_cnt), DW'(exp_ovs));
      chk($sformatf("vec%0d_outstanding", i), DW'(outstanding), '0);
    end

    // Withhold B: sixteen bursts go out, the seventeenth waits for a response.
    b_budget = 0;
    aw_cnt = 0;
    for (int i = 0; i < 17; i++) send_pkt(16'd64, 64'(i * 64), 40'(i), 8'd0, ONES, 0, 0);
    repeat (200) @(negedge clk);
    chk("maxout_aw_cnt", DW'(aw_cnt), DW'(16));
    chk("maxout_outstanding", DW'(outstanding), DW'(16));
    chk("maxout_plen_valid", DW'(bif.axis_plen_tvalid), DW'(1'b1));
    chk("maxout_plen_tready", DW'(bif.axis_plen_tready), '0);
    chk("maxout_addr_tready", DW'(bif.axis_addr_tready), '0);
    b_force_err = 1'b1;
    b_budget = 1;
    repeat (20) @(negedge clk);
    chk("release_aw_cnt", DW'(aw_cnt), DW'(17));
    chk("release_bresp_err", DW'(bresp_err_cnt), DW'(exp_berr));
    chk("release_outstanding", DW'(outstanding), DW'(16));
    b_force_err = 1'b0;
    b_budget = 1000000;
    drain("maxout", 2000);

    pv_pct = 60; dv_pct = 75; aw_pct = 60; w_pct = 70; b_pct = 60; b_err_pct = 5;
    for (int i = 0; i < 1000; i++) begin
      plen = ($urandom_range(0, 99) == 0) ? int'($urandom_range(16385, 65535))
                                          : int'($urandom_range(0, 700));
      n = m_beats(plen);
      send_pkt(16'(plen), {$urandom, $urandom}, rand_user(), 8'(n - 1), m_strb(plen), n - 1,
               (plen > 256 * BPB) ? 1 : 0);
    end
    drain("random", 60000);
    chk("random_outstanding", DW'(outstanding), '0);
    chk("random_oversize", DW'(oversize_cnt), DW'(exp_ovs));
    chk("random_tlast_err", DW'(tlast_err_cnt), DW'(exp_terr));
    chk("random_bresp_err", DW'(bresp_err_cnt), DW'(exp_berr));

    pv_pct = 100; dv_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 100; b_err_pct = 0;
    send_pkt(16'd20000, 64'hC000, 40'h0C, 8'd255, ONES, 255, 1);
    base = w_cnt;
    n = 0;
    while (w_cnt < base + 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached_w", DW'(n < 2000), DW'(1'b1));
    #2 reset = 1'b1;
    pa_q.delete(); d_q.delete(); aw_q.delete(); w_q.delete();
    bpend = 0; exp_terr = 0; exp_ovs = 0; exp_berr = 0;
    @(negedge clk);
    chk("midrst_awvalid", DW'(bif.m_axi_awvalid), '0);
    chk("midrst_wvalid", DW'(bif.m_axi_wvalid), '0);
    chk("midrst_wlast", DW'(bif.m_axi_wlast), '0);
    chk("midrst_data_tready", DW'(bif.axis_data_tready), '0);
    chk("midrst_bready", DW'(bif.m_axi_bready), '0);
    chk("midrst_awlen", DW'(bif.m_axi_awlen), '0);
    chk("midrst_awaddr", DW'(bif.m_axi_awaddr), '0);
    chk("midrst_outstanding", DW'(outstanding), '0);
    chk("midrst_counters", DW'({tlast_err_cnt, bresp_err_cnt, oversize_cnt}), '0);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    send_pkt(16'd100, 64'hD000, 40'h0D, 8'd1, 64'h0000_000F_FFFF_FFFF, 1, 0);
    drain("post_reset", 2000);
    chk("post_reset_counters", DW'({tlast_err_cnt, bresp_err_cnt, oversize_cnt}), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
